// File: rtl/manchester_rx_deser_if.sv
// Signal bundle between a Manchester line source / byte consumer (master)
// and the Manchester receiver-deserializer (slave).
interface manchester_rx_deser_if;
   logic       ena;
   logic       line_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       code_err;
   logic       busy;

   modport master (
      output ena,
      output line_in,
      input  data_out,
      input  data_valid,
      input  frame_err,
      input  code_err,
      input  busy
   );

   modport slave (
      input  ena,
      input  line_in,
      output data_out,
      output data_valid,
      output frame_err,
      output code_err,
      output busy
   );
endinterface

// File: rtl/manchester_rx_deser.sv
// Manchester line receiver: synchronizes the line, locks bit timing to the start
// edge, decodes 8 bits MSB-first and reports bytes, framing and coding faults.
module manchester_rx_deser #(
   parameter int HALF_BIT_CYCLES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   manchester_rx_deser_if.slave bus
);

   localparam int CELL_CYCLES = 2 * HALF_BIT_CYCLES;
   localparam int CW          = $clog2(CELL_CYCLES);

   localparam logic [CW-1:0] FIRST_SAMPLE  = CW'(HALF_BIT_CYCLES / 2);
   localparam logic [CW-1:0] SECOND_SAMPLE = CW'(HALF_BIT_CYCLES + HALF_BIT_CYCLES / 2);
   localparam logic [CW-1:0] LAST_CYC      = CW'(CELL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      DONE
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cyc_q;
   logic [CW-1:0]   cyc_d;
   logic [2:0]      bitIdx_q;
   logic [7:0]      shiftReg_q;
   logic [7:0]      shiftReg_d;
   logic            firstHalf_q;
   logic            sync1_q;
   logic            rin_q;
   logic            rinDly_q;
   logic            riseEdge;
   logic [7:0]      dataOut_q;
   logic            dataValid_q;
   logic            frameErr_q;
   logic            codeErr_q;
   logic            busy_q;

   assign cyc_d      = (cyc_q == LAST_CYC) ? '0 : cyc_q + CW'(1);
   assign shiftReg_d = {shiftReg_q[6:0], firstHalf_q};
   assign riseEdge   = rin_q & ~rinDly_q;

   // Synchronizer flops come out of reset high so a line already high is not
   // mistaken for a start edge; it must fall and rise again first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         rin_q       <= 1'b1;
         rinDly_q    <= 1'b1;
         state_q     <= IDLE;
         cyc_q       <= '0;
         bitIdx_q    <= 3'd0;
         shiftReg_q  <= 8'h00;
         firstHalf_q <= 1'b0;
         dataOut_q   <= 8'h00;
         dataValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
         codeErr_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= bus.line_in;
         rin_q       <= sync1_q;
         rinDly_q    <= rin_q;
         dataValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
         codeErr_q   <= 1'b0;
         if (!bus.ena) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            cyc_q <= cyc_d;
            unique case (state_q)
               IDLE: begin
                  cyc_q <= '0;
                  if (riseEdge) begin
                     state_q <= START;
                     busy_q  <= 1'b1;
                  end
               end
               START: begin
                  if (((cyc_q == FIRST_SAMPLE) || (cyc_q == SECOND_SAMPLE)) && !rin_q) begin
                     frameErr_q <= 1'b1;
                     state_q    <= IDLE;
                     busy_q     <= 1'b0;
                  end else if (cyc_q == LAST_CYC) begin
                     state_q  <= DATA;
                     bitIdx_q <= 3'd7;
                  end
               end
               DATA: begin
                  // A legal cell always has differing halves; the first half is the bit value.
                  if (cyc_q == FIRST_SAMPLE) begin
                     firstHalf_q <= rin_q;
                  end else if (cyc_q == SECOND_SAMPLE) begin
                     if (firstHalf_q == rin_q) begin
                        codeErr_q <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                     end else begin
                        shiftReg_q <= shiftReg_d;
                        if (bitIdx_q == 3'd0) begin
                           dataOut_q   <= shiftReg_d;
                           dataValid_q <= 1'b1;
                           state_q     <= DONE;
                        end else begin
                           bitIdx_q <= bitIdx_q - 3'd1;
                        end
                     end
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.data_out   = dataOut_q;
   assign bus.data_valid = dataValid_q;
   assign bus.frame_err  = frameErr_q;
   assign bus.code_err   = codeErr_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_manchester_rx_deser.sv
// Scoreboard bench for the Manchester receiver: stimulus pushes expected strobes
// (kind, byte, arrival cycle); a negedge monitor pops and compares them.
module tb_manchester_rx_deser;

   localparam int H    = 4;
   localparam int CELL = 2 * H;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cycle;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   tbCycle = 0;
   exp_t expQ[$];

   manchester_rx_deser_if bus();

   manchester_rx_deser #(.HALF_BIT_CYCLES(H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tbCycle <= tbCycle + 1;

   // Monitor: every strobe must match the head of the scoreboard in kind, cycle and data.
   always @(negedge clk) begin
      int   nStrobe;
      int   kind;
      exp_t e;
      nStrobe = int'(bus.data_valid) + int'(bus.frame_err) + int'(bus.code_err);
      kind    = bus.data_valid ? 0 : (bus.frame_err ? 1 : 2);
      if (nStrobe > 1) begin
         checks++;
         errors++;
         $display("[TB] FAIL strobeExclusive: %0d strobes high at cycle %0d, required at most 1",
                  nStrobe, tbCycle);
      end else if (nStrobe == 1) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpectedStrobe: kind %0d at cycle %0d, required no strobe",
                     kind, tbCycle);
         end else begin
            e = expQ.pop_front();
            if (kind != e.kind || tbCycle != e.cycle || (kind == 0 && bus.data_out != e.data)) begin
               errors++;
               $display("[TB] FAIL strobe: got kind %0d cycle %0d data 0x%02h, required kind %0d cycle %0d data 0x%02h",
                        kind, tbCycle, bus.data_out, e.kind, e.cycle, e.data);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%02h, required 0x%02h", name, actual, required);
      end
   endtask

   task automatic sendCell(input logic firstHalf, input logic secondHalf);
      bus.line_in = firstHalf;
      repeat (H) @(negedge clk);
      bus.line_in = secondHalf;
      repeat (H) @(negedge clk);
   endtask

   task automatic idleCells(input int n);
      bus.line_in = 1'b0;
      repeat (n * CELL) @(negedge clk);
   endtask

   // Sends a frame starting at a negedge. badBit >= 0 replaces that bit with 2'b11 and
   // ends the frame; resetBit >= 0 pulses rst_n for one cycle inside that bit and ends it.
   task automatic applyStimulus(input logic [7:0] d, input int badBit, input int resetBit,
                                input bit expectOut);
      int   startCycle;
      exp_t e;
      startCycle = tbCycle;
      if (expectOut && badBit < 0 && resetBit < 0) begin
         e.kind  = 0;
         e.data  = d;
         e.cycle = startCycle + 8 * CELL + H + H / 2 + 4;
         expQ.push_back(e);
      end
      if (expectOut && badBit >= 0) begin
         e.kind  = 2;
         e.data  = 8'h00;
         e.cycle = startCycle + (8 - badBit) * CELL + H + H / 2 + 4;
         expQ.push_back(e);
      end
      sendCell(1'b1, 1'b1);
      for (int b = 7; b >= 0; b--) begin
         if (b == badBit) begin
            sendCell(1'b1, 1'b1);
            bus.line_in = 1'b0;
            return;
         end
         if (b == resetBit) begin
            bus.line_in = d[b];
            repeat (2) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            bus.line_in = 1'b0;
            return;
         end
         sendCell(d[b], ~d[b]);
      end
      bus.line_in = 1'b0;
   endtask

   task automatic sendGlitch(input int highCycles);
      exp_t e;
      e.kind  = 1;
      e.data  = 8'h00;
      e.cycle = tbCycle + H / 2 + 4;
      expQ.push_back(e);
      bus.line_in = 1'b1;
      repeat (highCycles) @(negedge clk);
      bus.line_in = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s: %0d expected strobes never arrived, required 0 pending",
                  name, expQ.size());
         expQ.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", tbCycle);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      bus.ena     = 1'b1;
      bus.line_in = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetDataOut", bus.data_out, 8'h00);
      checkOutput("resetDataValid", {7'd0, bus.data_valid}, 8'h00);
      checkOutput("resetFrameErr", {7'd0, bus.frame_err}, 8'h00);
      checkOutput("resetCodeErr", {7'd0, bus.code_err}, 8'h00);
      checkOutput("resetBusy", {7'd0, bus.busy}, 8'h00);
      rst_n = 1'b1;
      idleCells(2);

      $display("[TB] test 1: frame 0xB2");
      applyStimulus(8'hB2, -1, -1, 1'b1);
      waitDrain("t1Drain");
      checkOutput("t1DataOut", bus.data_out, 8'hB2);
      checkOutput("t1BusyAfter", {7'd0, bus.busy}, 8'h00);

      $display("[TB] test 2: 0xF0 then 0x0F, one idle cell apart");
      idleCells(1);
      applyStimulus(8'hF0, -1, -1, 1'b1);
      idleCells(1);
      applyStimulus(8'h0F, -1, -1, 1'b1);
      waitDrain("t2Drain");
      checkOutput("t2DataOut", bus.data_out, 8'h0F);

      $display("[TB] test 3: 0xA5 with bit 4 coded 2'b11");
      idleCells(1);
      applyStimulus(8'hA5, 4, -1, 1'b1);
      waitDrain("t3Drain");
      checkOutput("t3DataOutHeld", bus.data_out, 8'h0F);
      checkOutput("t3BusyAfter", {7'd0, bus.busy}, 8'h00);

      $display("[TB] test 4: 3-clock glitch then frame 0x3C");
      idleCells(1);
      sendGlitch(3);
      idleCells(1);
      applyStimulus(8'h3C, -1, -1, 1'b1);
      waitDrain("t4Drain");
      checkOutput("t4DataOut", bus.data_out, 8'h3C);

      $display("[TB] test 5: reset during bit 5, then frame 0x81");
      idleCells(1);
      applyStimulus(8'h6E, -1, 5, 1'b0);
      checkOutput("t5ResetDataOut", bus.data_out, 8'h00);
      checkOutput("t5ResetBusy", {7'd0, bus.busy}, 8'h00);
      idleCells(1);
      applyStimulus(8'h81, -1, -1, 1'b1);
      waitDrain("t5Drain");
      checkOutput("t5DataOut", bus.data_out, 8'h81);

      $display("[TB] test 6: ena low ignores 0x55, ena high receives it");
      bus.ena = 1'b0;
      idleCells(1);
      applyStimulus(8'h55, -1, -1, 1'b0);
      idleCells(1);
      checkOutput("t6BusyDisabled", {7'd0, bus.busy}, 8'h00);
      checkOutput("t6DataOutHeld", bus.data_out, 8'h81);
      bus.ena = 1'b1;
      idleCells(1);
      applyStimulus(8'h55, -1, -1, 1'b1);
      waitDrain("t6Drain");
      checkOutput("t6DataOut", bus.data_out, 8'h55);

      idleCells(1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
